regfile_mp_sb: RTL and testbench

// - Parametrised multi-port register file for the pipelined datapath; successor to the

---
 rtl/regfile_mp_sb.sv | 86 ++++++++
 tb/tb_regfile_mp_sb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file (2 write ports, NREAD read ports) with busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_mp_sb #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic [1:0]                  WEN,
    input  logic [1:0][AW-1:0]          wsel,
    input  logic [1:0][WIDTH-1:0]       wdat,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_sel,
    input  logic [NREAD-1:0][AW-1:0]    rsel,
    output logic [NREAD-1:0][WIDTH-1:0] rdat,
    output logic [NREAD-1:0]            rbusy,
    output logic [AW:0]                 busy_cnt
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Port 1 is applied after port 0 so it wins on an address collision;
    // the reservation is applied last so it overrides a same-cycle release.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned p = 0; p < 2; p++) begin
            if (WEN[p] && !is_zero(wsel[p])) begin
                regs_d[wsel[p]] = wdat[p];
                busy_d[wsel[p]] = 1'b0;
            end
        end
        if (rsv_en && !is_zero(rsv_sel))
            busy_d[rsv_sel] = 1'b1;
        cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin
            rdat[i]  = regs_q[rsel[i]];
            rbusy[i] = busy_q[rsel[i]];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned p = 0; p < 2; p++) begin
                if (WEN[p] && (wsel[p] == rsel[i]) && !is_zero(rsel[i])) begin
                    rdat[i]  = wdat[p];
                    rbusy[i] = rsv_en && (rsv_sel == rsel[i]);
                end
            end
`endif
            if (is_zero(rsel[i])) begin
                rdat[i]  = '0;
                rbusy[i] = 1'b0;
            end
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed steps plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_mp_sb;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       WEN;
    logic [1:0][4:0]  wsel;
    logic [1:0][31:0] wdat;
    logic             rsv_en;
    logic [4:0]       rsv_sel;
    logic [1:0][4:0]  rsel;
    logic [1:0][31:0] rdat;
    logic [1:0]       rbusy;
    logic [5:0]       busy_cnt;

    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];

    regfile_mp_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut (
        .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsel(rsel), .rdat(rdat),
        .rbusy(rbusy), .busy_cnt(busy_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 0;
        end
    endtask

    // Architectural effect of one clock edge
    task automatic model_apply();
        for (int p = 0; p < 2; p++)
            if (WEN[p] && wsel[p] != 0) begin
                mregs[wsel[p]] = wdat[p];
                mbusy[wsel[p]] = 0;
            end
        if (rsv_en && rsv_sel != 0) mbusy[rsv_sel] = 1;
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] ed;
        logic        eb;
        for (int i = 0; i < 2; i++) begin
            ed = mregs[rsel[i]];
            eb = mbusy[rsel[i]];
`ifdef REGFILE_BYPASS_EN
            if (WEN[1] && wsel[1] == rsel[i]) begin
                ed = wdat[1];
                eb = rsv_en && rsv_sel == rsel[i];
            end else if (WEN[0] && wsel[0] == rsel[i]) begin
                ed = wdat[0];
                eb = rsv_en && rsv_sel == rsel[i];
            end
`endif
            if (rsel[i] == 0) begin
                ed = '0;
                eb = 1'b0;
            end
            check({tag, "_rdat"}, rdat[i], ed);
            check({tag, "_rbusy"}, 32'(rbusy[i]), 32'(eb));
        end
        check({tag, "_cnt"}, 32'(busy_cnt), 32'(model_cnt()));
    endtask

    task automatic idle();
        WEN = '0;
        rsv_en = 1'b0;
    endtask

    // Inputs are set after a negedge; check comb reads, clock, land on next negedge
    task automatic tick(input string tag);
        #1 check_all(tag);
        @(posedge CLK);
        model_apply();
        @(negedge CLK);
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        wsel = '0; wdat = '0; rsv_sel = '0; rsel = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        rsel = {5'd4, 5'd0};
        tick("reset_state");

        // Preload, then asynchronous reset mid-cycle
        for (int i = 0; i < 8; i++) begin
            WEN = 2'b11;
            wsel = {5'(i + 10), 5'(i + 1)};
            wdat = {$urandom, $urandom};
            rsv_en = 1'b1;
            rsv_sel = 5'(i + 20);
            tick("preload");
        end
        idle();
        rsel = {5'd20, 5'd3};
        #3 nRST = 1'b0;
        #1;
        check("async_rst_rdat0", rdat[0], 32'h0);
        check("async_rst_rdat1", rdat[1], 32'h0);
        check("async_rst_rbusy", 32'(rbusy), 32'h0);
        check("async_rst_cnt", 32'(busy_cnt), 32'h0);
        model_reset();
        WEN = 2'b01; wsel = {5'd0, 5'd3}; wdat = {32'h0, 32'h55}; rsv_en = 1'b1; rsv_sel = 5'd20;
        @(posedge CLK);
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        tick("rst_discard");

        WEN = 2'b01; wsel = {5'd0, 5'd5}; wdat = {32'h0, 32'hDEADBEEF};
        tick("wr_r5");
        idle(); rsel = {5'd0, 5'd5};
        #1 check("r5_value", rdat[0], 32'hDEADBEEF);
        tick("rd_r5");
        WEN = 2'b01; wsel = {5'd0, 5'd0}; wdat = {32'h0, 32'h1234};
        tick("wr_r0");
        idle(); rsel = {5'd5, 5'd0};
        #1 check("r0_zero", rdat[0], 32'h0);
        tick("rd_r0");

        WEN = 2'b11; wsel = {5'd7, 5'd7}; wdat = {32'h22, 32'h11};
        tick("dual_wr_r7");
        idle(); rsel = {5'd0, 5'd7};
        #1 check("r7_port1_wins", rdat[0], 32'h22);
        tick("rd_r7");

        rsv_en = 1'b1; rsv_sel = 5'd3; rsel = {5'd0, 5'd3};
        tick("rsv_r3");
        idle();
        #1 check("r3_busy", 32'(rbusy[0]), 32'h1);
        check("r3_cnt1", 32'(busy_cnt), 32'h1);
        WEN = 2'b01; wsel = {5'd0, 5'd3}; wdat = {32'h0, 32'h33}; rsv_en = 1'b1; rsv_sel = 5'd3;
        tick("rsv_and_clr_r3");
        idle();
        #1 check("r3_rsv_wins", 32'(rbusy[0]), 32'h1);
        check("r3_cnt_still1", 32'(busy_cnt), 32'h1);
        WEN = 2'b10; wsel = {5'd3, 5'd0}; wdat = {32'h44, 32'h0};
        tick("clr_r3");
        idle();
        #1 check("r3_released", 32'(rbusy[0]), 32'h0);
        check("cnt_zero", 32'(busy_cnt), 32'h0);

        for (int r = 1; r < 32; r++) begin
            rsv_en = 1'b1; rsv_sel = 5'(r); rsel = {5'(r), 5'(r - 1)};
            tick("rsv_all");
        end
        rsv_sel = 5'd1;
        tick("rsv_r1_again");
        #1 check("cnt_full_no_wrap", 32'(busy_cnt), 32'd31);
        rsv_sel = 5'd0; rsel = {5'd0, 5'd31};
        tick("rsv_r0");
        idle();
        #1 check("cnt_r0_ignored", 32'(busy_cnt), 32'd31);

        WEN = 2'b01; wsel = {5'd0, 5'd9}; wdat = {32'h0, 32'h5A5A0009};
        tick("wr_r9_old");
        WEN = 2'b01; wsel = {5'd0, 5'd9}; wdat = {32'h0, 32'hA5A5A5A5}; rsel = {5'd0, 5'd9};
`ifdef REGFILE_BYPASS_EN
        #1 check("bypass_r9", rdat[0], 32'hA5A5A5A5);
`else
        #1 check("no_bypass_r9", rdat[0], 32'h5A5A0009);
`endif
        tick("bypass_step");
        idle();

        for (int n = 0; n < 300; n++) begin
            WEN = 2'($urandom);
            wsel = {5'($urandom), 5'($urandom)};
            if ($urandom_range(0, 3) == 0) wsel[1] = wsel[0];
            wdat = {$urandom, $urandom};
            rsv_en = 1'($urandom);
            rsv_sel = ($urandom_range(0, 2) == 0) ? wsel[0] : 5'($urandom);
            rsel = {($urandom_range(0, 1) == 0) ? wsel[1] : 5'($urandom), 5'($urandom)};
            tick("random");
        end
        idle();
        tick("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
